// File: rtl/seq_chunk_adder_pkg.sv
// Shared definitions for the sequential chunked adder:
// state encoding, default geometry and a clog2 helper.
package seq_chunk_adder_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   localparam int unsigned DEF_W     = 32;
   localparam int unsigned DEF_CHUNK = 8;

   // Ceiling log2, never below 1 so a counter always has a bit.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(v)) r = i + 1;
      end
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/seq_chunk_adder_chunk.sv
// Combinational CHUNK-bit slice adder used by seq_chunk_adder:
// {co, s} = x + y + ci.
module chunk_adder #(
   parameter int unsigned CHUNK = 8
) (
   input  logic [CHUNK-1:0] x,
   input  logic [CHUNK-1:0] y,
   input  logic             ci,
   output logic [CHUNK-1:0] s,
   output logic             co
);

   assign {co, s} = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle W-bit adder, CHUNK bits per clock, LSB chunk first.
// Optional signed overflow output enabled by SEQ_ADD_OVF_EN.
module seq_chunk_adder
   import seq_chunk_adder_pkg::*;
#(
   parameter int unsigned W     = DEF_W,
   parameter int unsigned CHUNK = DEF_CHUNK
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] sum,
   output logic         cout
`ifdef SEQ_ADD_OVF_EN
   ,
   output logic         ovf
`endif
);

   localparam int unsigned N  = W / CHUNK;
   localparam int unsigned CW = clog2(N);
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   localparam bit LEGAL = (CHUNK == 1 || CHUNK == 2 || CHUNK == 4 ||
                           CHUNK == 8 || CHUNK == 16 || CHUNK == 32) &&
                          (W >= CHUNK) && (W % CHUNK == 0);

   generate
      if (!LEGAL) begin : g_illegal
         $error("seq_chunk_adder: illegal W/CHUNK combination");
      end
   endgenerate

   state_e         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [W-1:0]   a_q, a_d;
   logic [W-1:0]   b_q, b_d;
   logic           carry_q, carry_d;
   logic [W-1:0]   sum_q, sum_d;
   logic           cout_q, cout_d;
   logic           done_q, done_d;

   logic [CHUNK-1:0] s;
   logic             co;
   logic [W-1:0]     sum_sh;

   chunk_adder #(.CHUNK(CHUNK)) u_chunk (
      .x  (a_q[CHUNK-1:0]),
      .y  (b_q[CHUNK-1:0]),
      .ci (carry_q),
      .s  (s),
      .co (co)
   );

   // New chunk enters at the top; after N shifts the LSB chunk sits at bit 0.
   generate
      if (CHUNK < W) begin : g_shift
         assign sum_sh = {s, sum_q[W-1:CHUNK]};
      end else begin : g_full
         assign sum_sh = s;
      end
   endgenerate

`ifdef SEQ_ADD_OVF_EN
   logic a_msb_q, a_msb_d;
   logic b_msb_q, b_msb_d;
   logic ovf_q, ovf_d;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      done_d  = 1'b0;
`ifdef SEQ_ADD_OVF_EN
      a_msb_d = a_msb_q;
      b_msb_d = b_msb_q;
      ovf_d   = ovf_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
               a_d     = a;
               b_d     = b;
               carry_d = cin;
               cnt_d   = '0;
               sum_d   = '0;
`ifdef SEQ_ADD_OVF_EN
               a_msb_d = a[W-1];
               b_msb_d = b[W-1];
               ovf_d   = 1'b0;
`endif
            end
         end
         ST_RUN: begin
            carry_d = co;
            a_d     = a_q >> CHUNK;
            b_d     = b_q >> CHUNK;
            sum_d   = sum_sh;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               done_d  = 1'b1;
               cout_d  = co;
`ifdef SEQ_ADD_OVF_EN
               ovf_d   = (a_msb_q == b_msb_q) && (s[CHUNK-1] != a_msb_q);
`endif
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         done_q  <= done_d;
      end
   end

`ifdef SEQ_ADD_OVF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         a_msb_q <= a_msb_d;
         b_msb_q <= b_msb_d;
         ovf_q   <= ovf_d;
      end
   end

   assign ovf = ovf_q;
`endif

   assign busy = (state_q == ST_RUN);
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Self-checking bench for seq_chunk_adder at CHUNK = 8, 1 and 32
// against a plain-arithmetic golden model.
module tb_seq_chunk_adder;

   logic        clk;
   logic        rst_n;
   logic [2:0]  st;
   logic [31:0] a, b;
   logic        cin;

   logic [2:0]  busy_w, done_w, cout_w, ovf_w;
   logic [31:0] sum_w [3];

   int n_run;
   int n_fail;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   seq_chunk_adder #(.W(32), .CHUNK(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(st[0]),
      .a(a), .b(b), .cin(cin),
      .busy(busy_w[0]), .done(done_w[0]),
      .sum(sum_w[0]), .cout(cout_w[0])
`ifdef SEQ_ADD_OVF_EN
      , .ovf(ovf_w[0])
`endif
   );

   seq_chunk_adder #(.W(32), .CHUNK(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(st[1]),
      .a(a), .b(b), .cin(cin),
      .busy(busy_w[1]), .done(done_w[1]),
      .sum(sum_w[1]), .cout(cout_w[1])
`ifdef SEQ_ADD_OVF_EN
      , .ovf(ovf_w[1])
`endif
   );

   seq_chunk_adder #(.W(32), .CHUNK(32)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .start(st[2]),
      .a(a), .b(b), .cin(cin),
      .busy(busy_w[2]), .done(done_w[2]),
      .sum(sum_w[2]), .cout(cout_w[2])
`ifdef SEQ_ADD_OVF_EN
      , .ovf(ovf_w[2])
`endif
   );

`ifndef SEQ_ADD_OVF_EN
   assign ovf_w = 3'b000;
`endif

   function automatic int lat_of(input int sel);
      return (sel == 0) ? 4 : (sel == 1) ? 32 : 1;
   endfunction

   // Drives one operation on DUT sel and reports what it observed.
   task automatic run_op(input int sel,
                         input logic [31:0] ia, input logic [31:0] ib,
                         input logic ic,
                         output logic [31:0] osum, output logic ocout,
                         output logic oovf, output int lat,
                         output int bcnt, output logic obusy);
      @(negedge clk);
      a = ia; b = ib; cin = ic;
      st[sel] = 1'b1;
      @(posedge clk);
      lat = 0;
      bcnt = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         st[sel] = 1'b0;
         if (done_w[sel]) break;
         if (busy_w[sel]) bcnt++;
         @(posedge clk);
         lat++;
      end
      osum  = sum_w[sel];
      ocout = cout_w[sel];
      oovf  = ovf_w[sel];
      obusy = busy_w[sel];
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      st = 3'b000;
      a = '0; b = '0; cin = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         n_run++;
         if ({busy_w[i], done_w[i], sum_w[i], cout_w[i], ovf_w[i]} !== 36'd0) begin
            n_fail++;
            $display("FAIL reset_state dut%0d: busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
                     i, busy_w[i], done_w[i], sum_w[i], cout_w[i], ovf_w[i]);
         end
      end
   endtask

   task automatic test_basic();
      logic [31:0] s;
      logic c, o, bz;
      int lat, bc;
      run_op(0, 32'd15, 32'd10, 1'b0, s, c, o, lat, bc, bz);
      n_run++;
      if ({c, s} !== {1'b0, 32'd25}) begin
         n_fail++;
         $display("FAIL add_15_10: sum=%0d cout=%b, want 25/0", s, c);
      end
      n_run++;
      if (lat !== 4) begin
         n_fail++;
         $display("FAIL latency_8: got %0d, want 4", lat);
      end
      n_run++;
      if (bc !== 4 || bz !== 1'b0) begin
         n_fail++;
         $display("FAIL busy_window: busy cycles=%0d busy_at_done=%b, want 4/0", bc, bz);
      end
      run_op(0, 32'hFFFFFFFF, 32'd1, 1'b0, s, c, o, lat, bc, bz);
      n_run++;
      if ({c, s} !== {1'b1, 32'd0}) begin
         n_fail++;
         $display("FAIL wrap_carry: sum=%h cout=%b, want 0/1", s, c);
      end
      run_op(0, 32'd100, 32'd50, 1'b1, s, c, o, lat, bc, bz);
      n_run++;
      if ({c, s} !== {1'b0, 32'd151}) begin
         n_fail++;
         $display("FAIL add_cin: sum=%0d cout=%b, want 151/0", s, c);
      end
   endtask

`ifdef SEQ_ADD_OVF_EN
   task automatic test_ovf();
      logic [31:0] s;
      logic c, o, bz;
      int lat, bc;
      run_op(0, 32'h7FFFFFFF, 32'd1, 1'b0, s, c, o, lat, bc, bz);
      n_run++;
      if ({o, c, s} !== {1'b1, 1'b0, 32'h80000000}) begin
         n_fail++;
         $display("FAIL ovf_pos: sum=%h cout=%b ovf=%b, want 80000000/0/1", s, c, o);
      end
      run_op(0, 32'h80000000, 32'h80000000, 1'b0, s, c, o, lat, bc, bz);
      n_run++;
      if ({o, c, s} !== {1'b1, 1'b1, 32'h0}) begin
         n_fail++;
         $display("FAIL ovf_neg: sum=%h cout=%b ovf=%b, want 0/1/1", s, c, o);
      end
      run_op(0, 32'd3, 32'd4, 1'b0, s, c, o, lat, bc, bz);
      n_run++;
      if (o !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_clear: ovf=%b, want 0", o);
      end
   endtask
`endif

   // start held high across two ops; the second is taken in the done cycle.
   task automatic test_back_to_back();
      int d_cyc [$];
      logic [31:0] d_sum [$];
      @(negedge clk);
      a = 32'd12; b = 32'd3; cin = 1'b0;
      st[0] = 1'b1;
      for (int cyc = 1; cyc <= 16; cyc++) begin
         @(posedge clk);
         @(negedge clk);
         if (cyc == 1) begin
            a = 32'd5; b = 32'd6;
         end
         if (d_cyc.size() == 1 && cyc == d_cyc[0] + 1) st[0] = 1'b0;
         if (done_w[0]) begin
            d_cyc.push_back(cyc);
            d_sum.push_back(sum_w[0]);
         end
      end
      st[0] = 1'b0;
      n_run++;
      if (d_cyc.size() != 2) begin
         n_fail++;
         $display("FAIL b2b_count: done pulses=%0d, want 2", d_cyc.size());
      end else begin
         n_run++;
         if (d_sum[0] !== 32'd15 || d_sum[1] !== 32'd11) begin
            n_fail++;
            $display("FAIL b2b_sums: got %0d,%0d want 15,11", d_sum[0], d_sum[1]);
         end
         n_run++;
         if (d_cyc[1] - d_cyc[0] != 5) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d cycles, want 5", d_cyc[1] - d_cyc[0]);
         end
      end
   endtask

   task automatic test_reset_midop();
      logic [31:0] s;
      logic c, o, bz;
      int lat, bc, ndone;
      @(negedge clk);
      a = 32'hA5A5A5A5; b = 32'h5A5A5A5A; cin = 1'b0;
      st[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      st[0] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_run++;
      if ({busy_w[0], done_w[0], sum_w[0], cout_w[0]} !== 35'd0) begin
         n_fail++;
         $display("FAIL midop_reset: busy=%b done=%b sum=%h cout=%b, want all 0",
                  busy_w[0], done_w[0], sum_w[0], cout_w[0]);
      end
      ndone = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done_w[0]) ndone++;
      end
      n_run++;
      if (ndone != 0) begin
         n_fail++;
         $display("FAIL midop_no_done: saw %0d done pulses, want 0", ndone);
      end
      run_op(0, 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, s, c, o, lat, bc, bz);
      n_run++;
      if ({c, s} !== {1'b0, 32'hFFFFFFFF}) begin
         n_fail++;
         $display("FAIL midop_retry: sum=%h cout=%b, want FFFFFFFF/0", s, c);
      end
   endtask

   task automatic test_chunk_widths();
      logic [31:0] s;
      logic c, o, bz;
      int lat, bc;
      for (int sel = 1; sel <= 2; sel++) begin
         run_op(sel, 32'd15, 32'd10, 1'b0, s, c, o, lat, bc, bz);
         n_run++;
         if ({c, s} !== {1'b0, 32'd25} || lat !== lat_of(sel)) begin
            n_fail++;
            $display("FAIL chunk_basic dut%0d: sum=%0d cout=%b lat=%0d, want 25/0/%0d",
                     sel, s, c, lat, lat_of(sel));
         end
         run_op(sel, 32'hFFFFFFFF, 32'd1, 1'b0, s, c, o, lat, bc, bz);
         n_run++;
         if ({c, s} !== {1'b1, 32'd0}) begin
            n_fail++;
            $display("FAIL chunk_wrap dut%0d: sum=%h cout=%b, want 0/1", sel, s, c);
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] s, ra, rb;
      logic [32:0] gold;
      logic c, o, bz, rc, go;
      int lat, bc, cnt, sel;
      for (int i = 0; i < 1300; i++) begin
         sel = (i < 1000) ? 0 : (i < 1100) ? 1 : 2;
         ra = $urandom;
         rb = $urandom;
         rc = 1'($urandom_range(1, 0));
         if (i % 50 == 0) rb = ~ra;
         gold = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
`ifdef SEQ_ADD_OVF_EN
         go = (ra[31] == rb[31]) && (gold[31] != ra[31]);
`else
         go = 1'b0;
`endif
         run_op(sel, ra, rb, rc, s, c, o, lat, bc, bz);
         n_run++;
         if ({c, s} !== gold || o !== go || lat !== lat_of(sel)) begin
            n_fail++;
            $display("FAIL random dut%0d: %h+%h+%b got %b_%h ovf=%b lat=%0d want %h ovf=%b lat=%0d",
                     sel, ra, rb, rc, c, s, o, lat, gold, go, lat_of(sel));
         end
      end
   endtask

   initial begin
      n_run = 0;
      n_fail = 0;
      test_reset();
      test_basic();
`ifdef SEQ_ADD_OVF_EN
      test_ovf();
`endif
      test_back_to_back();
      repeat (8) @(negedge clk);
      test_reset_midop();
      test_chunk_widths();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
